// File: rtl/multicycle_state_seq.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_state_seq
//  Brief    : Control-state sequencer for the multicycle MIPS CPU. Holds the
//             3-bit control state, advances it from the current opcode with
//             instruction/data memory stalls, detects halt and illegal
//             opcodes, and keeps retired-instruction and cycle counters.
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_state_seq #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [5:0]       opcode,
    input  logic             inst_ready,
    input  logic             mem_ready,
    output logic [2:0]       state,
    output logic             halted,
    output logic             illegal,
    output logic             retire,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_AEXE = 3'b110,
        S_BEXE = 3'b101,
        S_CEXE = 3'b010,
        S_MEM  = 3'b011,
        S_AWB  = 3'b111,
        S_CWB  = 3'b100
    } state_t;

    localparam logic [5:0] c_op_add  = 6'b000000;
    localparam logic [5:0] c_op_sub  = 6'b000001;
    localparam logic [5:0] c_op_addi = 6'b000010;
    localparam logic [5:0] c_op_or   = 6'b010000;
    localparam logic [5:0] c_op_and  = 6'b010001;
    localparam logic [5:0] c_op_ori  = 6'b010010;
    localparam logic [5:0] c_op_sll  = 6'b011000;
    localparam logic [5:0] c_op_move = 6'b100000;
    localparam logic [5:0] c_op_slt  = 6'b100111;
    localparam logic [5:0] c_op_sw   = 6'b110000;
    localparam logic [5:0] c_op_lw   = 6'b110001;
    localparam logic [5:0] c_op_beq  = 6'b110100;
    localparam logic [5:0] c_op_j    = 6'b111000;
    localparam logic [5:0] c_op_jr   = 6'b111001;
    localparam logic [5:0] c_op_jal  = 6'b111010;
    localparam logic [5:0] c_op_halt = 6'b111111;

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    state_t           r_state;
    logic             r_halted;
    logic             r_illegal;
    logic             r_retire;
    logic [CNT_W-1:0] r_instr_count;
    logic [CNT_W-1:0] r_cycle_count;

    // Sequencer: next control state, pulses, sticky halt and both counters.
    // Once halted everything freezes with the state parked at IF; pulses are
    // cleared every cycle so they last exactly one cycle.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_state       <= S_IF;
            r_halted      <= 1'b0;
            r_illegal     <= 1'b0;
            r_retire      <= 1'b0;
            r_instr_count <= '0;
            r_cycle_count <= '0;
        end else begin
            r_illegal <= 1'b0;
            r_retire  <= 1'b0;
            if (!r_halted) begin
                r_cycle_count <= r_cycle_count + c_one;
                case (r_state)
                    S_IF: begin
                        if (inst_ready) begin
                            r_state <= S_ID;
                        end
                    end
                    S_ID: begin
                        case (opcode)
                            c_op_beq: r_state <= S_BEXE;
                            c_op_sw, c_op_lw: r_state <= S_CEXE;
                            c_op_add, c_op_sub, c_op_addi, c_op_or, c_op_and,
                            c_op_ori, c_op_sll, c_op_move, c_op_slt:
                                r_state <= S_AEXE;
                            c_op_j, c_op_jr, c_op_jal: begin
                                r_state       <= S_IF;
                                r_retire      <= 1'b1;
                                r_instr_count <= r_instr_count + c_one;
                            end
                            c_op_halt: begin
                                r_state       <= S_IF;
                                r_retire      <= 1'b1;
                                r_halted      <= 1'b1;
                                r_instr_count <= r_instr_count + c_one;
                            end
                            default: begin
                                // Undefined opcode is abandoned but still retires.
                                r_state       <= S_IF;
                                r_retire      <= 1'b1;
                                r_illegal     <= 1'b1;
                                r_instr_count <= r_instr_count + c_one;
                            end
                        endcase
                    end
                    S_AEXE: r_state <= S_AWB;
                    S_CEXE: r_state <= S_MEM;
                    S_MEM: begin
                        if (mem_ready) begin
                            if (opcode == c_op_lw) begin
                                r_state <= S_CWB;
                            end else begin
                                r_state       <= S_IF;
                                r_retire      <= 1'b1;
                                r_instr_count <= r_instr_count + c_one;
                            end
                        end
                    end
                    S_AWB, S_BEXE, S_CWB: begin
                        r_state       <= S_IF;
                        r_retire      <= 1'b1;
                        r_instr_count <= r_instr_count + c_one;
                    end
                    default: r_state <= S_IF;
                endcase
            end
        end
    end

    assign state       = r_state;
    assign halted      = r_halted;
    assign illegal     = r_illegal;
    assign retire      = r_retire;
    assign instr_count = r_instr_count;
    assign cycle_count = r_cycle_count;

endmodule
`default_nettype wire
